program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, the instruction memory word-address width.
REQ-002 SHALL have parameter DEPTH, default 256, the maximum loadable word count (DEPTH <= 2^ADDR_W).
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port Init  input  1  asynchronous active-high reset.
REQ-005 SHALL have port Program  input  1  level request to load a program.
REQ-006 SHALL have port in_valid  input  1  the byte-stream source has in_data valid.
REQ-007 SHALL have port in_data  input  8  byte-stream data.
REQ-008 SHALL have port in_ready  output  1  the loader accepts a byte this cycle.
REQ-009 SHALL have port imem_we  output  1  instruction memory write strobe.
REQ-010 SHALL have port imem_addr  output  ADDR_W  instruction memory word address.
REQ-011 SHALL have port imem_wdata  output  32  instruction word to write.
REQ-012 SHALL have port cpu_hold  output  1  holds the downstream CPU in reset while high.
REQ-013 SHALL have port done  output  1  load completed successfully.
REQ-014 SHALL have port err  output  1  sticky load failure flag.

Function
REQ-015 SHALL transfer a byte only on a cycle with in_valid=1 and in_ready=1.
REQ-016 SHALL implement states IDLE, HDR0, HDR1, DATA, WRITE, DONE; all outputs registered.
REQ-017 IDLE: in_ready=0, cpu_hold=0; Program=1 -> HDR0, clear err, done, byte and word counters.
REQ-018 HDR0/HDR1: in_ready=1; accept count N[7:0] then N[15:8] (little-endian).
REQ-019 On the HDR1 transfer: N=0 -> DONE; N>DEPTH -> IDLE with err=1; else -> DATA.
REQ-020 DATA: in_ready=1; assemble 4 bytes little-endian (first byte -> bits 7:0); the 4th transfer -> WRITE.
REQ-021 WRITE: lasts exactly one cycle; imem_we=1, in_ready=0, imem_addr=word counter, imem_wdata=assembled word.
REQ-022 Write latency SHALL be one cycle: 4th byte accepted at edge t, imem_we high during cycle t+1.
REQ-023 After WRITE, the word counter SHALL increment; counter==N -> DONE, else -> DATA.
REQ-024 Addresses SHALL start at 0 and increment by 1 per word; no wrap is possible because N<=DEPTH.
REQ-025 cpu_hold SHALL be 1 in HDR0, HDR1, DATA and WRITE, and 0 in IDLE and DONE.
REQ-026 DONE: done=1, in_ready=0; stays until Program=0, then -> IDLE with done cleared.
REQ-027 Program=0 in HDR0, HDR1, DATA or WRITE SHALL abort -> IDLE, set err=1 and discard the partial word; an abort in WRITE still completes that cycle's write.
REQ-028 err SHALL remain set until the next IDLE->HDR0 transition.
REQ-029 in_valid while in_ready=0 SHALL be ignored; no byte is consumed.
REQ-030 imem_we SHALL never be high outside WRITE.

Reset
REQ-031 Init=1 SHALL immediately, without waiting for a CLK edge, force IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=0, done=0, err=0, and clear all counters.
REQ-032 Init asserted mid-load SHALL abandon the load with no further memory writes; after Init falls, Program=1 starts a fresh load from HDR0.
REQ-033 Release of Init SHALL not cause a transfer or write on the same edge.

Verification
REQ-034 Stream 02 00 | 13 00 01 20 | FF FF 02 8C, Program=1, in_valid continuous -> writes 0x20010013@0 and 0x8C02FFFF@1; done=1; cpu_hold high from the cycle after Program rises until DONE.
REQ-035 Header 00 00 -> DONE with zero imem_we pulses and err=0.
REQ-036 Header 01 01 (N=257 > DEPTH) -> IDLE, err=1, no writes, cpu_hold=0.
REQ-037 Load of N=3 with in_valid toggling every other cycle -> same written words as with a continuous stream; no byte is lost or duplicated.
REQ-038 Program dropped after 2 bytes of word 1 -> only word 0 is written; IDLE; err=1; the next Program=1 clears err.
REQ-039 Init pulsed during DATA between CLK edges -> all outputs reach reset values before the next edge; no write follows.

Source files
------------

// File: rtl/program_loader.sv
// Boot loader: takes a 16-bit little-endian word count, then that many 32-bit little-endian words,
// and writes them to instruction memory from address 0 while holding the CPU in reset.
module program_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              CLK,
    input  logic              Init,
    input  logic              Program,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        WRITE,
        DONE
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t state, state_d;

    logic [7:0]        n_lo, n_lo_d;
    logic [15:0]       n_cnt, n_cnt_d;
    logic [1:0]        byte_cnt, byte_cnt_d;
    logic [15:0]       word_cnt, word_cnt_d;
    logic [23:0]       word_buf, word_buf_d;
    logic              err_d, done_d;
    logic              in_ready_d, imem_we_d, cpu_hold_d;
    logic [ADDR_W-1:0] imem_addr_d;
    logic [31:0]       imem_wdata_d;
    logic              xfer;
    logic [15:0]       hdr_n;

    always_ff @(posedge CLK or posedge Init) begin
        if (Init) begin
            state      <= IDLE;
            n_lo       <= '0;
            n_cnt      <= '0;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            word_buf   <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            cpu_hold   <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            state      <= state_d;
            n_lo       <= n_lo_d;
            n_cnt      <= n_cnt_d;
            byte_cnt   <= byte_cnt_d;
            word_cnt   <= word_cnt_d;
            word_buf   <= word_buf_d;
            err        <= err_d;
            done       <= done_d;
            in_ready   <= in_ready_d;
            imem_we    <= imem_we_d;
            cpu_hold   <= cpu_hold_d;
            imem_addr  <= imem_addr_d;
            imem_wdata <= imem_wdata_d;
        end
    end

    always_comb begin
        state_d      = state;
        n_lo_d       = n_lo;
        n_cnt_d      = n_cnt;
        byte_cnt_d   = byte_cnt;
        word_cnt_d   = word_cnt;
        word_buf_d   = word_buf;
        err_d        = err;
        done_d       = done;
        imem_addr_d  = imem_addr;
        imem_wdata_d = imem_wdata;
        xfer         = in_valid && in_ready;
        hdr_n        = {in_data, n_lo};

        case (state)
            IDLE: begin
                if (Program) begin
                    state_d    = HDR0;
                    err_d      = 1'b0;
                    done_d     = 1'b0;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                end
            end
            HDR0: begin
                if (!Program) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (xfer) begin
                    n_lo_d  = in_data;
                    state_d = HDR1;
                end
            end
            HDR1: begin
                if (!Program) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (xfer) begin
                    n_cnt_d = hdr_n;
                    if (hdr_n == 16'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if ({1'b0, hdr_n} > DEPTH_L) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (!Program) begin
                    // Partial word is dropped; the next load restarts byte assembly.
                    state_d    = IDLE;
                    err_d      = 1'b1;
                    byte_cnt_d = '0;
                end else if (xfer) begin
                    byte_cnt_d = byte_cnt + 2'd1;
                    case (byte_cnt)
                        2'd0:    word_buf_d[7:0]   = in_data;
                        2'd1:    word_buf_d[15:8]  = in_data;
                        2'd2:    word_buf_d[23:16] = in_data;
                        default: begin
                            state_d      = WRITE;
                            imem_addr_d  = word_cnt[ADDR_W-1:0];
                            imem_wdata_d = {in_data, word_buf};
                        end
                    endcase
                end
            end
            WRITE: begin
                word_cnt_d = word_cnt + 16'd1;
                if (!Program) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (word_cnt_d == n_cnt) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = DATA;
                end
            end
            DONE: begin
                if (!Program) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flow-control and strobe outputs are registered copies of the next state's decode.
        in_ready_d = (state_d == HDR0) || (state_d == HDR1) || (state_d == DATA);
        imem_we_d  = (state_d == WRITE);
        cpu_hold_d = in_ready_d || imem_we_d;
    end

endmodule
